// File: rtl/memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port memory bus.
// Each accepted request is issued to memory as one strobe, then the response returns to its master.
module memory_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          RESET_PRIORITY = 1'b0
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        M0Cycle,
    input  logic        M0Strobe,
    input  logic        M0ReadWrite,
    input  logic [1:0]  M0Width,
    input  logic [31:0] M0Address,
    input  logic [31:0] M0DataIn,
    output logic [31:0] M0DataOut,
    output logic        M0Acknowledge,
    output logic        M0Error,
    output logic        M0Stall,
    input  logic        M1Cycle,
    input  logic        M1Strobe,
    input  logic        M1ReadWrite,
    input  logic [1:0]  M1Width,
    input  logic [31:0] M1Address,
    input  logic [31:0] M1DataIn,
    output logic [31:0] M1DataOut,
    output logic        M1Acknowledge,
    output logic        M1Error,
    output logic        M1Stall,
    output logic        SCycle,
    output logic        SStrobe,
    output logic        SReadWrite,
    output logic [1:0]  SWidth,
    output logic [31:0] SAddress,
    output logic [31:0] SDataOut,
    input  logic [31:0] SDataIn,
    input  logic        SAcknowledge,
    input  logic        SStall
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t         state;
    logic           priority_q;   // master that wins the next contended arbitration
    logic           owner;
    logic           aborted;
    logic           rw_q;
    logic [1:0]     width_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    dout0;
    logic [31:0]    dout1;
    logic           ack0, ack1, err0, err1;
    logic           s_cycle, s_strobe;
    logic [CW-1:0]  count;

    logic req0, req1, win0, win1, idle, owner_cycle;

    assign req0        = M0Cycle & M0Strobe;
    assign req1        = M1Cycle & M1Strobe;
    assign win0        = req0 & (~req1 | ~priority_q);
    assign win1        = req1 & (~req0 |  priority_q);
    assign idle        = (state == IDLE);
    assign owner_cycle = owner ? M1Cycle : M0Cycle;

    // NOTE: Stall is combinational on the live request; gating with ResetN keeps it 0 while in reset.
    assign M0Stall = ResetN & req0 & ~(idle & win0);
    assign M1Stall = ResetN & req1 & ~(idle & win1);

    assign M0DataOut     = dout0;
    assign M1DataOut     = dout1;
    assign M0Acknowledge = ack0;
    assign M1Acknowledge = ack1;
    assign M0Error       = err0;
    assign M1Error       = err1;
    assign SCycle        = s_cycle;
    assign SStrobe       = s_strobe;
    assign SReadWrite    = rw_q;
    assign SWidth        = width_q;
    assign SAddress      = addr_q;
    assign SDataOut      = wdata_q;

    // NOTE: the data registers are async-reset too, so every output reads 0 during reset.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state      <= IDLE;
            priority_q <= RESET_PRIORITY;
            owner      <= 1'b0;
            aborted    <= 1'b0;
            rw_q       <= 1'b0;
            width_q    <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            dout0      <= 32'd0;
            dout1      <= 32'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            s_cycle    <= 1'b0;
            s_strobe   <= 1'b0;
            count      <= '0;
        end else begin
            // NOTE: response pulses default low every cycle; only the WAIT->RESPOND edge raises one.
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (win0 | win1) begin
                        owner      <= win1;
                        priority_q <= win0;
                        rw_q       <= win1 ? M1ReadWrite : M0ReadWrite;
                        width_q    <= win1 ? M1Width     : M0Width;
                        addr_q     <= win1 ? M1Address   : M0Address;
                        wdata_q    <= win1 ? M1DataIn    : M0DataIn;
                        aborted    <= 1'b0;
                        s_cycle    <= 1'b1;
                        s_strobe   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!owner_cycle) aborted <= 1'b1;
                    if (!SStall) begin
                        s_strobe <= 1'b0;
                        count    <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!owner_cycle) aborted <= 1'b1;
                    if (SAcknowledge || count == LAST) begin
                        s_cycle <= 1'b0;
                        state   <= RESPOND;
                        // An abandoned transaction still finishes on memory but reports nothing.
                        if (!aborted && owner_cycle) begin
                            if (SAcknowledge) begin
                                ack0 <= ~owner;
                                ack1 <=  owner;
                                if (!rw_q && width_q != 2'd3) begin
                                    if (owner) dout1 <= SDataIn;
                                    else       dout0 <= SDataIn;
                                end
                            end else begin
                                err0 <= ~owner;
                                err1 <=  owner;
                            end
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboarded bench for memory_arbiter with a byte-addressed memory model that has
// programmable ack delay, strobe stall and ack suppression.
`timescale 1ns/1ps
module tb_memory_arbiter;

    localparam int TIMEOUT = 16;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        M0Cycle = 1'b0, M0Strobe = 1'b0, M0ReadWrite = 1'b0;
    logic [1:0]  M0Width = 2'd0;
    logic [31:0] M0Address = 32'd0, M0DataIn = 32'd0;
    logic        M1Cycle = 1'b0, M1Strobe = 1'b0, M1ReadWrite = 1'b0;
    logic [1:0]  M1Width = 2'd0;
    logic [31:0] M1Address = 32'd0, M1DataIn = 32'd0;
    logic [31:0] M0DataOut, M1DataOut;
    logic        M0Acknowledge, M0Error, M0Stall, M1Acknowledge, M1Error, M1Stall;
    logic        SCycle, SStrobe, SReadWrite;
    logic [1:0]  SWidth;
    logic [31:0] SAddress, SDataOut;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        mem_stall;

    memory_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .RESET_PRIORITY(1'b0)) dut (
        .Clock(Clock), .ResetN(ResetN),
        .M0Cycle(M0Cycle), .M0Strobe(M0Strobe), .M0ReadWrite(M0ReadWrite), .M0Width(M0Width),
        .M0Address(M0Address), .M0DataIn(M0DataIn), .M0DataOut(M0DataOut),
        .M0Acknowledge(M0Acknowledge), .M0Error(M0Error), .M0Stall(M0Stall),
        .M1Cycle(M1Cycle), .M1Strobe(M1Strobe), .M1ReadWrite(M1ReadWrite), .M1Width(M1Width),
        .M1Address(M1Address), .M1DataIn(M1DataIn), .M1DataOut(M1DataOut),
        .M1Acknowledge(M1Acknowledge), .M1Error(M1Error), .M1Stall(M1Stall),
        .SCycle(SCycle), .SStrobe(SStrobe), .SReadWrite(SReadWrite), .SWidth(SWidth),
        .SAddress(SAddress), .SDataOut(SDataOut), .SDataIn(mem_rdata),
        .SAcknowledge(mem_ack), .SStall(mem_stall)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    int  ack_delay    = 1;
    bit  ack_enable   = 1'b1;
    int  stall_cycles = 0;
    int  stall_cnt    = 0;
    int  pend         = 0;
    logic [7:0] mem [0:255];

    assign mem_stall = SStrobe && (stall_cnt < stall_cycles);

    initial begin : mem_model
        logic [7:0]  a;
        logic [31:0] rd;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hDEADBEEF;
        {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14]} = 32'h12345678;
        {mem[8'h1B], mem[8'h1A], mem[8'h19], mem[8'h18]} = 32'hCAFEF00D;
        {mem[8'h1F], mem[8'h1E], mem[8'h1D], mem[8'h1C]} = 32'h0BADC0DE;
        forever begin
            @(posedge Clock);
            mem_ack <= 1'b0;
            if (pend > 0) begin
                pend <= pend - 1;
                if (pend == 1) mem_ack <= ack_enable;
            end
            if (SCycle && SStrobe) begin
                if (mem_stall) begin
                    stall_cnt <= stall_cnt + 1;
                end else begin
                    stall_cnt <= 0;
                    a = SAddress[7:0];
                    if (SReadWrite) begin
                        if (SWidth != 2'd3)
                            for (int b = 0; b < (1 << SWidth); b++) mem[8'(a + b)] = SDataOut[8*b +: 8];
                    end else begin
                        rd = {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[a]};
                        if (SWidth == 2'd0) rd = {24'h0, rd[7:0]};
                        else if (SWidth == 2'd1) rd = {16'h0, rd[15:0]};
                        mem_rdata <= rd;
                    end
                    if (ack_delay <= 1) mem_ack <= ack_enable;
                    else pend <= ack_delay - 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          m;
        bit          err;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];
    logic [31:0] exp_dout [2];

    function automatic void sb_push(input int m, input bit err, input logic [31:0] data);
        exp_t e;
        e.m = m; e.err = err; e.data = data;
        sb_q.push_back(e);
    endfunction

    always @(negedge Clock) begin : monitor
        logic [3:0] pulses, want;
        exp_t e;
        pulses = {M0Acknowledge, M0Error, M1Acknowledge, M1Error};
        if (ResetN && pulses != 4'b0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_response", {28'h0, pulses}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                want = (e.m == 0) ? (e.err ? 4'b0100 : 4'b1000) : (e.err ? 4'b0001 : 4'b0010);
                check($sformatf("resp_pulses_m%0d", e.m), {28'h0, pulses}, {28'h0, want});
                check($sformatf("resp_dout_m%0d", e.m), (e.m == 0) ? M0DataOut : M1DataOut, e.data);
            end
        end
    end

    int stb_count = 0;
    int stb_last  = 0;
    always @(negedge Clock) if (SStrobe) begin stb_count++; stb_last = cyc; end

    // ---------------- master drivers ----------------
    task automatic drive(input int m, input logic c, input logic s, input logic rw,
                         input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            M0Cycle = c; M0Strobe = s; M0ReadWrite = rw; M0Width = w; M0Address = a; M0DataIn = d;
        end else begin
            M1Cycle = c; M1Strobe = s; M1ReadWrite = rw; M1Width = w; M1Address = a; M1DataIn = d;
        end
    endtask

    function automatic logic stall_of(input int m);
        return (m == 0) ? M0Stall : M1Stall;
    endfunction

    function automatic logic resp_of(input int m);
        return (m == 0) ? (M0Acknowledge | M0Error) : (M1Acknowledge | M1Error);
    endfunction

    // Holds the request until Acknowledge/Error, checking the stall-low-once rule and latency.
    task automatic run_txn(input int m, input logic rw, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] d, input int exp_lat, output int acc);
        int lows = 0;
        bit done = 1'b0;
        int lat  = 0;
        acc = -1;
        @(posedge Clock); #1;
        drive(m, 1'b1, 1'b1, rw, w, a, d);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge Clock);
            if (!stall_of(m)) begin
                lows++;
                if (acc < 0) acc = cyc;
            end
            if (resp_of(m)) begin
                done = 1'b1;
                lat  = cyc - acc;
            end
        end
        drive(m, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        check($sformatf("txn_done_m%0d", m), {31'h0, done}, 32'h1);
        check($sformatf("stall_low_once_m%0d", m), lows, 1);
        if (exp_lat >= 0) check($sformatf("latency_m%0d", m), lat, exp_lat);
    endtask

    task automatic wait_for_wait_state(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge Clock);
            if (SCycle && !SStrobe) found = 1'b1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stimulus
        int acc, stb0, resp_cyc;
        bit found;

        // Reset with both masters requesting: everything must read 0.
        drive(0, 1'b1, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h14, 32'h0);
        repeat (2) @(negedge Clock);
        check("rst_stall", {30'h0, M0Stall, M1Stall}, 32'h0);
        check("rst_ctrl", {23'h0, M0Acknowledge, M0Error, M1Acknowledge, M1Error,
                           SCycle, SStrobe, SReadWrite, SWidth}, 32'h0);
        check("rst_saddr", SAddress, 32'h0);
        check("rst_sdata", SDataOut, 32'h0);
        check("rst_m0_dout", M0DataOut, 32'h0);
        check("rst_m1_dout", M1DataOut, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        ResetN = 1'b1;

        // Continuous contention from reset: grants M0, M1, M0, M1.
        sb_push(0, 1'b0, 32'hDEADBEEF);
        sb_push(1, 1'b0, 32'h12345678);
        sb_push(0, 1'b0, 32'hCAFEF00D);
        sb_push(1, 1'b0, 32'h0BADC0DE);
        fork
            begin : m0_stream
                int a0;
                run_txn(0, 1'b0, 2'd2, 32'h10, 32'h0, 3, a0);
                run_txn(0, 1'b0, 2'd2, 32'h18, 32'h0, 3, a0);
            end
            begin : m1_stream
                int a1;
                run_txn(1, 1'b0, 2'd2, 32'h14, 32'h0, 3, a1);
                run_txn(1, 1'b0, 2'd2, 32'h1C, 32'h0, 3, a1);
            end
        join
        exp_dout[0] = 32'hCAFEF00D;
        exp_dout[1] = 32'h0BADC0DE;

        // Lone M0 word read: strobe in cycle 1, acknowledge in cycle 3.
        stb0 = stb_count;
        exp_dout[0] = 32'hDEADBEEF;
        sb_push(0, 1'b0, exp_dout[0]);
        run_txn(0, 1'b0, 2'd2, 32'h10, 32'h0, 3, acc);
        check("single_strobe_count", stb_count - stb0, 1);
        check("single_strobe_cycle", stb_last, acc + 1);
        check("idle_m1_dout", M1DataOut, 32'h0BADC0DE);

        // M1 half write with two memory stall cycles, then M0 half read back.
        stall_cycles = 2;
        sb_push(1, 1'b0, exp_dout[1]);
        run_txn(1, 1'b1, 2'd1, 32'h20, 32'h5555ABCD, 5, acc);
        stall_cycles = 0;
        exp_dout[0] = 32'h0000ABCD;
        sb_push(0, 1'b0, exp_dout[0]);
        run_txn(0, 1'b0, 2'd1, 32'h20, 32'h0, 3, acc);

        // Reserved width: acknowledged, DataOut unchanged.
        sb_push(0, 1'b0, exp_dout[0]);
        run_txn(0, 1'b0, 2'd3, 32'h10, 32'h0, 3, acc);

        // Memory never acknowledges: M1 gets Error TIMEOUT cycles after entering WAIT.
        ack_enable = 1'b0;
        sb_push(1, 1'b1, exp_dout[1]);
        run_txn(1, 1'b0, 2'd2, 32'h10, 32'h0, TIMEOUT + 2, acc);
        ack_enable = 1'b1;

        // Reset while in WAIT; the late memory ack lands in IDLE and must be ignored.
        ack_delay = 3;
        @(posedge Clock); #1;
        drive(0, 1'b1, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
        wait_for_wait_state(found);
        check("rst_mid_reach_wait", {31'h0, found}, 32'h1);
        ResetN = 1'b0;
        #1;
        check("rst_mid_ctrl", {23'h0, M0Acknowledge, M0Error, M1Acknowledge, M1Error,
                               SCycle, SStrobe, SReadWrite, SWidth}, 32'h0);
        check("rst_mid_stall", {30'h0, M0Stall, M1Stall}, 32'h0);
        check("rst_mid_m0_dout", M0DataOut, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge Clock);
        ResetN = 1'b1;
        repeat (4) @(negedge Clock);
        ack_delay = 1;
        exp_dout[0] = 32'hDEADBEEF;
        exp_dout[1] = 32'h0;
        sb_push(0, 1'b0, exp_dout[0]);
        run_txn(0, 1'b0, 2'd2, 32'h10, 32'h0, 3, acc);

        // M0 abandons its read in WAIT: no response, DataOut kept, IDLE right after RESPOND.
        ack_delay = 3;
        @(posedge Clock); #1;
        drive(0, 1'b1, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
        wait_for_wait_state(found);
        check("abort_reach_wait", {31'h0, found}, 32'h1);
        drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        found = 1'b0;
        resp_cyc = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge Clock);
            if (!SCycle) begin found = 1'b1; resp_cyc = cyc; end
        end
        check("abort_reach_respond", {31'h0, found}, 32'h1);
        ack_delay = 1;
        exp_dout[1] = 32'h0000ABCD;
        sb_push(1, 1'b0, exp_dout[1]);
        run_txn(1, 1'b0, 2'd2, 32'h20, 32'h0, 3, acc);
        check("abort_idle_next", acc, resp_cyc + 1);
        check("abort_m0_dout", M0DataOut, exp_dout[0]);

        repeat (3) @(negedge Clock);
        check("scoreboard_drained", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
